hdlc_flag_tx: RTL and testbench

- Serial HDLC-style framer transmitter. Counterpart of the flag/sequence detector on the receive side.
- Accepts payload bytes over a valid/ready stream with an end-of-frame marker.
- Emits each frame on one serial line: opening flag 01111110, bit-stuffed payload (LSB first), closing flag.
- Sits between a byte source (FIFO or CPU register) and the serial pin, paced by a bit-rate strobe.

---
 rtl/hdlc_flag_tx.sv | 208 ++++++++++++++++++++
 tb/tb_hdlc_flag_tx.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/hdlc_flag_tx.sv
// hdlc_flag_tx: HDLC framer transmitter (flags, LSB-first bit-stuffed payload, abort on underrun).
// Define HDLC_TX_FCS_EN to append a CRC-16/X.25 FCS before the closing flag.
module hdlc_flag_tx #(
  parameter int OPEN_FLAGS = 1,
  parameter bit IDLE_MARK  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_en,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic       tx_out,
  output logic       busy,
  output logic       done,
  output logic       underrun
);
  typedef enum logic [2:0] {IDLE, OFLAG, DATA, STUFF, CFLAG, ABORT
`ifdef HDLC_TX_FCS_EN
    , FCS
`endif
  } state_t;
  localparam logic [7:0] FLAG = 8'h7E;
  state_t     state_q, state_d;
  logic [4:0] bcnt_q, bcnt_d;
  logic [3:0] fcnt_q, fcnt_d;
  logic [2:0] ones_q, ones_d;
  logic [7:0] sh_q, sh_d, buf_q, src;
  logic       last_q, last_d, tx_q, tx_d, done_q, done_d, und_q, und_d;
  logic       full_q, buf_last_q, take, emit, eb;
`ifdef HDLC_TX_FCS_EN
  logic [15:0] crc_q, crc_d;
  logic        ret_q, ret_d;
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    return {1'b0, c[15:1]} ^ ((c[0] ^ b) ? 16'h8408 : 16'h0000);
  endfunction
`endif
  assign in_ready = ~full_q;
  assign tx_out   = tx_q;
  assign busy     = state_q != IDLE;
  assign done     = done_q;
  assign underrun = und_q;
  // bcnt_q[3] in DATA marks a byte boundary: the next slot decides last/next byte/abort
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    fcnt_d  = fcnt_q;
    ones_d  = ones_q;
    sh_d    = sh_q;
    last_d  = last_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    und_d   = 1'b0;
    take    = 1'b0;
    emit    = 1'b0;
    eb      = 1'b0;
    src     = bcnt_q[3] ? buf_q : sh_q;
`ifdef HDLC_TX_FCS_EN
    crc_d   = crc_q;
    ret_d   = ret_q;
`endif
    if (bit_en) begin
      case (state_q)
        IDLE: begin
          tx_d = full_q ? FLAG[0] : IDLE_MARK;
          if (full_q) begin
            take    = 1'b1;
            sh_d    = buf_q;
            last_d  = buf_last_q;
            bcnt_d  = 5'd1;
            fcnt_d  = 4'd0;
            ones_d  = 3'd0;
            state_d = OFLAG;
`ifdef HDLC_TX_FCS_EN
            crc_d   = 16'hFFFF;
`endif
          end
        end
        OFLAG: begin
          tx_d   = FLAG[bcnt_q[2:0]];
          bcnt_d = (bcnt_q == 5'd7) ? 5'd0 : bcnt_q + 5'd1;
          if (bcnt_q == 5'd7) begin
            fcnt_d = fcnt_q + 4'd1;
            if (fcnt_q == 4'(OPEN_FLAGS - 1)) state_d = DATA;
          end
        end
        DATA: begin
          if (bcnt_q[3] && last_q) begin
`ifdef HDLC_TX_FCS_EN
            state_d = FCS;
            emit    = 1'b1;
            eb      = ~crc_q[0];
            crc_d   = {1'b0, ~crc_q[15:1]};
            bcnt_d  = 5'd1;
`else
            state_d = CFLAG;
            tx_d    = FLAG[0];
            bcnt_d  = 5'd1;
            ones_d  = 3'd0;
`endif
          end else if (bcnt_q[3] && !full_q) begin
            state_d = ABORT;
            tx_d    = 1'b1;
            bcnt_d  = 5'd1;
            und_d   = 1'b1;
          end else begin
            emit   = 1'b1;
            eb     = src[0];
            sh_d   = {1'b0, src[7:1]};
            bcnt_d = bcnt_q[3] ? 5'd1 : bcnt_q + 5'd1;
            take   = bcnt_q[3];
            last_d = bcnt_q[3] ? buf_last_q : last_q;
`ifdef HDLC_TX_FCS_EN
            crc_d  = crc_step(crc_q, src[0]);
`endif
          end
        end
        STUFF: begin
          tx_d    = 1'b0;
          ones_d  = 3'd0;
`ifdef HDLC_TX_FCS_EN
          state_d = ret_q ? FCS : DATA;
`else
          state_d = DATA;
`endif
        end
        CFLAG: begin
          tx_d    = bcnt_q[3] ? IDLE_MARK : FLAG[bcnt_q[2:0]];
          done_d  = bcnt_q[3];
          bcnt_d  = bcnt_q[3] ? 5'd0 : bcnt_q + 5'd1;
          state_d = bcnt_q[3] ? IDLE : CFLAG;
        end
        ABORT: begin
          tx_d    = (bcnt_q == 5'd7) ? IDLE_MARK : 1'b1;
          bcnt_d  = (bcnt_q == 5'd7) ? 5'd0 : bcnt_q + 5'd1;
          state_d = (bcnt_q == 5'd7) ? IDLE : ABORT;
        end
`ifdef HDLC_TX_FCS_EN
        FCS: begin
          if (bcnt_q[4]) begin
            state_d = CFLAG;
            tx_d    = FLAG[0];
            bcnt_d  = 5'd1;
            ones_d  = 3'd0;
          end else begin
            emit   = 1'b1;
            eb     = crc_q[0];
            crc_d  = {1'b0, crc_q[15:1]};
            bcnt_d = bcnt_q + 5'd1;
          end
        end
`endif
        default: state_d = IDLE;
      endcase
      if (emit) begin
        tx_d   = eb;
        ones_d = eb ? ones_q + 3'd1 : 3'd0;
        if (eb && ones_q == 3'd4) begin
`ifdef HDLC_TX_FCS_EN
          ret_d   = state_d == FCS;
`endif
          state_d = STUFF;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      bcnt_q     <= 5'd0;
      fcnt_q     <= 4'd0;
      ones_q     <= 3'd0;
      sh_q       <= 8'd0;
      last_q     <= 1'b0;
      tx_q       <= IDLE_MARK;
      done_q     <= 1'b0;
      und_q      <= 1'b0;
      full_q     <= 1'b0;
      buf_q      <= 8'd0;
      buf_last_q <= 1'b0;
`ifdef HDLC_TX_FCS_EN
      crc_q      <= 16'hFFFF;
      ret_q      <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      fcnt_q  <= fcnt_d;
      ones_q  <= ones_d;
      sh_q    <= sh_d;
      last_q  <= last_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      und_q   <= und_d;
`ifdef HDLC_TX_FCS_EN
      crc_q   <= crc_d;
      ret_q   <= ret_d;
`endif
      if (take) full_q <= 1'b0;
      else if (in_valid && !full_q) begin
        full_q     <= 1'b1;
        buf_q      <= in_data;
        buf_last_q <= in_last;
      end
    end
  end
endmodule

// File: tb/tb_hdlc_flag_tx.sv
// tb_hdlc_flag_tx: random and directed frames checked against a bit-list model of the HDLC framing rules.
module tb_hdlc_flag_tx;
  localparam int OF = 1;
  localparam bit IM = 1'b1;
  logic       clk = 1'b0, rst = 1'b0, bit_en = 1'b0, in_valid = 1'b0, in_last = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_ready, tx_out, busy, done, underrun;
  int         checks = 0, errors = 0;
  logic [7:0] pay[$];
  bit         exp_q[$], got[$];

  hdlc_flag_tx #(.OPEN_FLAGS(OF), .IDLE_MARK(IM)) dut (
    .clk(clk), .rst(rst), .bit_en(bit_en), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .tx_out(tx_out), .busy(busy),
    .done(done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] g, input logic [31:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, g, e);
    end
  endtask

  task automatic push_byte(input logic [7:0] b, inout int ones);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(b[i]);
      ones = b[i] ? ones + 1 : 0;
      if (ones == 5) begin
        exp_q.push_back(1'b0);
        ones = 0;
      end
    end
  endtask

  task automatic push_flag();
    logic [7:0] f = 8'h7E;
    for (int i = 0; i < 8; i++) exp_q.push_back(f[i]);
  endtask

  // expected serial frame from the framing rules: flags, stuffed bytes (+FCS), flag or abort
  task automatic build(input bit ab);
    int ones = 0;
    logic [15:0] crc = 16'hFFFF;
    exp_q.delete();
    repeat (OF) push_flag();
    foreach (pay[k]) begin
      push_byte(pay[k], ones);
      crc = crc ^ {8'h00, pay[k]};
      repeat (8) crc = crc[0] ? ((crc >> 1) ^ 16'h8408) : (crc >> 1);
    end
    if (ab) repeat (7) exp_q.push_back(1'b1);
    else begin
`ifdef HDLC_TX_FCS_EN
      crc = ~crc;
      push_byte(crc[7:0], ones);
      push_byte(crc[15:8], ones);
`endif
      push_flag();
    end
  endtask

  task automatic run(input string name, input int per, input bit rnd, input bit ab, input int rst_at);
    int nund = 0, ndone = 0, bcyc = 0, viol = 0;
    logic prev, rdy;
    bit wb = 1'b0, fin = 1'b0;
    build(ab);
    got.delete();
    prev = tx_out;
    for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
      @(negedge clk);
      bit_en = rnd ? ($urandom_range(0, 2) == 0) : (cyc % per == 0);
      rdy = in_ready;
      in_valid = rdy && pay.size() > 0;
      if (in_valid) begin
        in_data = pay[0];
        in_last = (pay.size() == 1) && !ab;
      end
      @(posedge clk);
      if (in_valid) void'(pay.pop_front());
      #1;
      if (underrun) nund++;
      if (done) ndone++;
      if (busy) bcyc++;
      if (!bit_en && tx_out !== prev) viol++;
      prev = tx_out;
      if (bit_en && busy) begin
        got.push_back(tx_out);
        if (got.size() == rst_at) begin
          #2 rst = 1'b0;
          #1;
          chk({name, " rst tx"}, tx_out, IM);
          chk({name, " rst busy"}, busy, 0);
          chk({name, " rst ready"}, in_ready, 1);
          pay.delete();
          in_valid = 1'b0;
          @(negedge clk) rst = 1'b1;
          return;
        end
      end else if (bit_en && wb) begin
        fin = 1'b1;
        chk({name, " idle tx"}, tx_out, IM);
      end
      wb = busy;
    end
    in_valid = 1'b0;
    bit_en = 1'b0;
    chk({name, " timeout"}, fin, 1);
    chk({name, " len"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chk($sformatf("%s bit%0d", name, i), got[i], exp_q[i]);
    chk({name, " underrun"}, nund, ab ? 1 : 0);
    chk({name, " done"}, ndone, ab ? 0 : 1);
    chk({name, " hold"}, viol, 0);
    if (per == 1 && !rnd) chk({name, " busy"}, bcyc, exp_q.size());
    @(posedge clk);
    #1 chk({name, " done clr"}, done, 0);
  endtask

  initial begin
    #12;
    chk("reset tx", tx_out, IM);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset underrun", underrun, 0);
    chk("reset ready", in_ready, 1);
    @(negedge clk) rst = 1'b1;
    bit_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle mark", tx_out, IM);
    pay = {8'h00};
    run("zero", 1, 0, 0, -1);
    pay = {8'hFF};
    run("ff", 1, 0, 0, -1);
    pay = {8'hFF, 8'hFF};
    run("ffff", 1, 0, 0, -1);
    pay = {8'h3C};
    run("abort", 1, 0, 1, -1);
    pay = {8'hA5};
    run("slow", 4, 0, 0, -1);
    pay = {8'hA5, 8'h5A};
    run("midrst", 1, 0, 0, OF * 8 + 3);
    pay = {8'h81};
    run("post", 1, 0, 0, -1);
`ifdef HDLC_TX_FCS_EN
    pay = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    run("fcs", 1, 0, 0, -1);
`endif
    for (int f = 0; f < 20; f++) begin
      int n = $urandom_range(1, 6);
      pay.delete();
      repeat (n) pay.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
      run($sformatf("rnd%0d", f), ($urandom_range(0, 1) == 0) ? 1 : 3, f % 2 == 1, 0, -1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
